// File: rtl/dual_step_accumulator.sv
// dual_step_accumulator
// Runs a bounded loop of n iterations. Each iteration steps two accumulators
// x and y by one of several patterns picked by the per-cycle selector, which
// also offers a stall. A start/busy/done handshake loads a new bound at run
// time. On the edge that finishes the loop, x+y is compared against the
// closed-form total (STEP_A+STEP_B)*n, and any disagreement sets the sticky
// err flag.
module dual_step_accumulator #(
    parameter int W          = 11,
    parameter int AW         = W + 2,
    parameter int STEP_A     = 1,
    parameter int STEP_B     = 2,
    parameter int N_DEFAULT  = 40,
    parameter int AUTO_START = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  n_in,
    input  logic [1:0]    selector,
    output logic [AW-1:0] x,
    output logic [AW-1:0] y,
    output logic [W-1:0]  i,
    output logic [W-1:0]  n,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [1:0] ST_RESET = (AUTO_START != 0) ? ST_RUN : ST_IDLE;

    localparam logic [AW-1:0] STEP_A_W   = AW'(STEP_A);
    localparam logic [AW-1:0] STEP_B_W   = AW'(STEP_B);
    localparam logic [AW-1:0] STEP_SUM_W = AW'(STEP_A + STEP_B);
    localparam logic [W-1:0]  N_RESET    = W'(N_DEFAULT);

    localparam logic [1:0] SEL_AB    = 2'b00;
    localparam logic [1:0] SEL_BA    = 2'b01;
    localparam logic [1:0] SEL_STALL = 2'b10;
    localparam logic [1:0] SEL_SUM   = 2'b11;

    logic [1:0]    state_r, state_nx_s;
    logic [AW-1:0] x_r, x_nx_s;
    logic [AW-1:0] y_r, y_nx_s;
    logic [W-1:0]  i_r, i_nx_s;
    logic [W-1:0]  n_r, n_nx_s;
    logic          err_r, err_nx_s;
    logic          busy_r, busy_nx_s;
    logic          done_r, done_nx_s;
    logic          last_step_s;

    // End-of-loop sum check: x+y must equal (STEP_A+STEP_B)*bound, both mod 2^AW.
    function automatic logic sum_mismatch(input logic [AW-1:0] a,
                                          input logic [AW-1:0] b,
                                          input logic [W-1:0]  bound);
        logic [AW-1:0] total;
        logic [AW-1:0] target;
        total  = a + b;
        target = STEP_SUM_W * AW'(bound);
        return (total != target);
    endfunction

    // Next-state and datapath update for the IDLE/RUN/DONE loop controller.
    always_comb begin
        state_nx_s  = state_r;
        x_nx_s      = x_r;
        y_nx_s      = y_r;
        i_nx_s      = i_r;
        n_nx_s      = n_r;
        err_nx_s    = err_r;
        last_step_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    n_nx_s     = n_in;
                    x_nx_s     = '0;
                    y_nx_s     = '0;
                    i_nx_s     = '0;
                    err_nx_s   = 1'b0;
                    state_nx_s = (n_in == '0) ? ST_DONE : ST_RUN;
                end else begin
                    state_nx_s = state_r;
                end
            end
            ST_RUN: begin
                if (i_r >= n_r) begin
                    // Defensive exit: compare what has been accumulated so far.
                    state_nx_s = ST_DONE;
                    err_nx_s   = err_r | sum_mismatch(x_r, y_r, n_r);
                end else begin
                    case (selector)
                        SEL_AB: begin
                            x_nx_s = x_r + STEP_A_W;
                            y_nx_s = y_r + STEP_B_W;
                            i_nx_s = i_r + W'(1);
                        end
                        SEL_BA: begin
                            x_nx_s = x_r + STEP_B_W;
                            y_nx_s = y_r + STEP_A_W;
                            i_nx_s = i_r + W'(1);
                        end
                        SEL_STALL: begin
                            i_nx_s = i_r;
                        end
                        SEL_SUM: begin
                            x_nx_s = x_r + STEP_SUM_W;
                            i_nx_s = i_r + W'(1);
                        end
                        default: begin
                            i_nx_s = i_r;
                        end
                    endcase
                    // Widened compare so i+1 cannot wrap before matching n.
                    last_step_s = (selector != SEL_STALL) &&
                                  (({1'b0, i_r} + (W+1)'(1)) == {1'b0, n_r});
                    if (last_step_s) begin
                        state_nx_s = ST_DONE;
                        err_nx_s   = err_r | sum_mismatch(x_nx_s, y_nx_s, n_r);
                    end else begin
                        state_nx_s = ST_RUN;
                    end
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
        busy_nx_s = (state_nx_s == ST_RUN);
        done_nx_s = (state_nx_s == ST_DONE);
    end

    // State, accumulator and status registers; asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_RESET;
            x_r     <= '0;
            y_r     <= '0;
            i_r     <= '0;
            n_r     <= N_RESET;
            err_r   <= 1'b0;
            busy_r  <= (ST_RESET == ST_RUN);
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            x_r     <= x_nx_s;
            y_r     <= y_nx_s;
            i_r     <= i_nx_s;
            n_r     <= n_nx_s;
            err_r   <= err_nx_s;
            busy_r  <= busy_nx_s;
            done_r  <= done_nx_s;
        end
    end

    assign x    = x_r;
    assign y    = y_r;
    assign i    = i_r;
    assign n    = n_r;
    assign err  = err_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_dual_step_accumulator.sv
// Directed bench for dual_step_accumulator. Two instances share the inputs:
// dut_a comes out of reset running (AUTO_START=1) and dut_i waits in IDLE
// (AUTO_START=0).
module tb_dual_step_accumulator;

    localparam int W  = 11;
    localparam int AW = W + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  n_in;
    logic [1:0]    selector;

    logic [AW-1:0] a_x, a_y, i_x, i_y;
    logic [W-1:0]  a_i, a_n, i_i, i_n;
    logic          a_busy, a_done, a_err, i_busy, i_done, i_err;

    int vectors = 0;
    int miscompares = 0;

    dual_step_accumulator #(.W(W), .AUTO_START(1)) dut_a (
        .clk(clk), .rst(rst), .start(start), .n_in(n_in), .selector(selector),
        .x(a_x), .y(a_y), .i(a_i), .n(a_n), .busy(a_busy), .done(a_done), .err(a_err)
    );

    dual_step_accumulator #(.W(W), .AUTO_START(0)) dut_i (
        .clk(clk), .rst(rst), .start(start), .n_in(n_in), .selector(selector),
        .x(i_x), .y(i_y), .i(i_i), .n(i_n), .busy(i_busy), .done(i_done), .err(i_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; n_in = '0; selector = 2'b00;
        repeat (3) tick();
        vectors++; if (a_x !== 13'd0) begin miscompares++; $display("FAIL reset_a_x got %0d expected 0", a_x); end
        vectors++; if (a_y !== 13'd0) begin miscompares++; $display("FAIL reset_a_y got %0d expected 0", a_y); end
        vectors++; if (a_i !== 11'd0) begin miscompares++; $display("FAIL reset_a_i got %0d expected 0", a_i); end
        vectors++; if (a_n !== 11'd40) begin miscompares++; $display("FAIL reset_a_n got %0d expected 40", a_n); end
        vectors++; if (a_busy !== 1'b1) begin miscompares++; $display("FAIL reset_a_busy got %0b expected 1", a_busy); end
        vectors++; if (a_done !== 1'b0 || a_err !== 1'b0) begin miscompares++; $display("FAIL reset_a_done_err got %0b%0b expected 00", a_done, a_err); end
        vectors++; if (i_busy !== 1'b0 || i_done !== 1'b0) begin miscompares++; $display("FAIL reset_i_busy_done got %0b%0b expected 00", i_busy, i_done); end
        vectors++; if (i_n !== 11'd40) begin miscompares++; $display("FAIL reset_i_n got %0d expected 40", i_n); end
    endtask

    task automatic test_auto_start();
        int k;
        rst = 1'b1;
        selector = 2'b00;
        k = 0;
        while (k < 60) begin
            tick();
            k++;
            if (a_done) break;
        end
        vectors++; if (k !== 40) begin miscompares++; $display("FAIL auto_cycles got %0d expected 40", k); end
        vectors++; if (a_x !== 13'd40 || a_y !== 13'd80) begin miscompares++; $display("FAIL auto_xy got %0d/%0d expected 40/80", a_x, a_y); end
        vectors++; if (a_i !== 11'd40 || a_n !== 11'd40) begin miscompares++; $display("FAIL auto_in got %0d/%0d expected 40/40", a_i, a_n); end
        vectors++; if (a_err !== 1'b0 || a_busy !== 1'b0) begin miscompares++; $display("FAIL auto_err_busy got %0b%0b expected 00", a_err, a_busy); end
        vectors++; if (i_busy !== 1'b0 || i_x !== 13'd0) begin miscompares++; $display("FAIL auto_idle_hold got busy=%0b x=%0d expected 0/0", i_busy, i_x); end
    endtask

    task automatic test_selector_mix();
        logic [1:0] seq [7];
        seq = '{2'b00, 2'b10, 2'b01, 2'b10, 2'b11, 2'b01, 2'b00};
        start = 1'b1; n_in = 11'd5;
        tick();
        start = 1'b0;
        vectors++; if (a_busy !== 1'b1 || a_done !== 1'b0 || a_i !== 11'd0 || a_n !== 11'd5) begin miscompares++; $display("FAIL mix_start got busy=%0b done=%0b i=%0d n=%0d expected 1/0/0/5", a_busy, a_done, a_i, a_n); end
        for (int j = 0; j < 7; j++) begin
            selector = seq[j];
            tick();
            vectors++; if (a_done !== (j == 6)) begin miscompares++; $display("FAIL mix_done_step%0d got %0b expected %0b", j, a_done, (j == 6)); end
        end
        vectors++; if (a_x !== 13'd9 || a_y !== 13'd6) begin miscompares++; $display("FAIL mix_xy got %0d/%0d expected 9/6", a_x, a_y); end
        vectors++; if (a_i !== 11'd5 || a_err !== 1'b0) begin miscompares++; $display("FAIL mix_i_err got %0d/%0b expected 5/0", a_i, a_err); end
        vectors++; if (i_x !== 13'd9 || i_y !== 13'd6 || i_done !== 1'b1) begin miscompares++; $display("FAIL mix_i_inst got %0d/%0d/%0b expected 9/6/1", i_x, i_y, i_done); end
    endtask

    task automatic test_start_in_run();
        int k;
        selector = 2'b00;
        start = 1'b1; n_in = 11'd10;
        tick();
        start = 1'b0;
        k = 0;
        repeat (4) begin tick(); k++; end
        start = 1'b1; n_in = 11'd3;
        tick(); k++;
        start = 1'b0;
        vectors++; if (a_n !== 11'd10 || a_busy !== 1'b1) begin miscompares++; $display("FAIL midstart_n got n=%0d busy=%0b expected 10/1", a_n, a_busy); end
        while (k < 40) begin
            tick();
            k++;
            if (a_done) break;
        end
        vectors++; if (k !== 10) begin miscompares++; $display("FAIL midstart_cycles got %0d expected 10", k); end
        vectors++; if (a_x + a_y !== 13'd30 || a_x !== 13'd10) begin miscompares++; $display("FAIL midstart_sum got x=%0d y=%0d expected 10/20", a_x, a_y); end
        vectors++; if (a_n !== 11'd10 || a_err !== 1'b0) begin miscompares++; $display("FAIL midstart_n_err got %0d/%0b expected 10/0", a_n, a_err); end
    endtask

    task automatic test_reset_mid_run();
        selector = 2'b00;
        start = 1'b1; n_in = 11'd40;
        tick();
        start = 1'b0;
        repeat (19) tick();
        vectors++; if (a_i !== 11'd19) begin miscompares++; $display("FAIL midrst_pre_i got %0d expected 19", a_i); end
        #3;
        rst = 1'b0;
        #1;
        vectors++; if (a_x !== 13'd0 || a_y !== 13'd0 || a_i !== 11'd0) begin miscompares++; $display("FAIL midrst_a_zero got %0d/%0d/%0d expected 0/0/0", a_x, a_y, a_i); end
        vectors++; if (a_n !== 11'd40 || a_done !== 1'b0) begin miscompares++; $display("FAIL midrst_a_n got n=%0d done=%0b expected 40/0", a_n, a_done); end
        vectors++; if (i_x !== 13'd0 || i_i !== 11'd0 || i_busy !== 1'b0 || i_done !== 1'b0) begin miscompares++; $display("FAIL midrst_i_zero got x=%0d i=%0d busy=%0b done=%0b expected 0/0/0/0", i_x, i_i, i_busy, i_done); end
        tick();
        rst = 1'b1;
        repeat (3) tick();
        vectors++; if (i_busy !== 1'b0 || i_done !== 1'b0 || i_i !== 11'd0) begin miscompares++; $display("FAIL midrst_idle got busy=%0b done=%0b i=%0d expected 0/0/0", i_busy, i_done, i_i); end
        vectors++; if (a_busy !== 1'b1 || a_i !== 11'd3) begin miscompares++; $display("FAIL midrst_autorun got busy=%0b i=%0d expected 1/3", a_busy, a_i); end
    endtask

    task automatic test_zero_bound();
        start = 1'b1; n_in = 11'd0;
        tick();
        start = 1'b0;
        vectors++; if (i_done !== 1'b1 || i_busy !== 1'b0) begin miscompares++; $display("FAIL zero_state got done=%0b busy=%0b expected 1/0", i_done, i_busy); end
        vectors++; if (i_x !== 13'd0 || i_y !== 13'd0 || i_i !== 11'd0 || i_n !== 11'd0 || i_err !== 1'b0) begin miscompares++; $display("FAIL zero_regs got x=%0d y=%0d i=%0d n=%0d err=%0b expected all 0", i_x, i_y, i_i, i_n, i_err); end
        tick();
        vectors++; if (i_done !== 1'b1 || i_busy !== 1'b0) begin miscompares++; $display("FAIL zero_hold got done=%0b busy=%0b expected 1/0", i_done, i_busy); end
    endtask

    task automatic test_back_to_back();
        int k;
        selector = 2'b01;
        start = 1'b1; n_in = 11'd2047;
        tick();
        start = 1'b0;
        vectors++; if (i_done !== 1'b0 || i_busy !== 1'b1 || i_i !== 11'd0 || i_n !== 11'd2047) begin miscompares++; $display("FAIL restart_clear got done=%0b busy=%0b i=%0d n=%0d expected 0/1/0/2047", i_done, i_busy, i_i, i_n); end
        k = 0;
        while (k < 2200) begin
            tick();
            k++;
            if (i_done) break;
        end
        vectors++; if (k !== 2047) begin miscompares++; $display("FAIL restart_cycles got %0d expected 2047", k); end
        vectors++; if (i_x !== 13'd4094 || i_y !== 13'd2047) begin miscompares++; $display("FAIL restart_xy got %0d/%0d expected 4094/2047", i_x, i_y); end
        vectors++; if (i_x + i_y !== 13'd6141 || i_err !== 1'b0 || i_i !== 11'd2047) begin miscompares++; $display("FAIL restart_sum got sum=%0d err=%0b i=%0d expected 6141/0/2047", i_x + i_y, i_err, i_i); end
    endtask

    initial begin
        test_reset();
        test_auto_start();
        test_selector_mix();
        test_start_in_run();
        test_reset_mid_run();
        test_zero_bound();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dual_step_accumulator.md
# dual_step_accumulator

Parametrised successor to the fixed selector-driven dual accumulator loop. The block runs a bounded loop of `n` iterations. Each iteration steps two accumulators `x` and `y` by configurable amounts, and a per-cycle `selector` mode chooses the step pattern, including a stall. It adds a start/busy/done handshake, a runtime-loadable bound, and a built-in end-of-loop sum check. It sits in the arithmetic-cases suite as the generalised loop-invariant test vehicle.

## Interface
- `W`, 11: width of `i`, `n`, `n_in`.
- `AW`, `W+2`: width of `x` and `y`.
- `STEP_A`, 1: small step.
- `STEP_B`, 2: large step.
- `N_DEFAULT`, 40: bound loaded at reset.
- `AUTO_START`, 1: 1 = enter RUN straight out of reset with `n=N_DEFAULT` (legacy behaviour); 0 = wait in IDLE.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `start`  in  1  load `n_in` and begin a loop; honoured in IDLE and DONE only.
- `n_in`  in  W  loop bound, sampled with `start`.
- `selector`  in  2  per-cycle step mode; only meaningful in RUN.
- `x`, `y`  out  AW  accumulators.
- `i`  out  W  iteration count.
- `n`  out  W  active bound.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `err`  out  1  sticky sum-check failure.

## Operation
- States: IDLE, RUN, DONE.
- Reset (`rst`=0, asynchronous):
  - `x=0`, `y=0`, `i=0`, `n=N_DEFAULT`, `err=0`.
  - State is RUN if `AUTO_START` else IDLE.
  - `busy`/`done` follow the state.
- IDLE/DONE with `start`=1:
  - `n<=n_in`; `x,y,i<=0`; `err<=0`.
  - Next state RUN, or DONE if `n_in==0`.
- IDLE/DONE with `start`=0: all registers hold.
- `start` in RUN is ignored.
- RUN step per `selector`:
  - 00: `x+=STEP_A`, `y+=STEP_B`, `i+=1`.
  - 01: `x+=STEP_B`, `y+=STEP_A`, `i+=1`.
  - 10: stall; all registers hold and `i` is not incremented.
  - 11: `x+=STEP_A+STEP_B`, `y` holds, `i+=1`.
- RUN ends: when a non-stall step makes `i+1==n`, the same edge moves the state to DONE.
- RUN guard: if `i>=n` in RUN (unreachable by construction), go to DONE without stepping.
- Sum check:
  - On the edge entering DONE, `err<=1` if `x+y` (post-step, mod 2^AW) != `(STEP_A+STEP_B)*n` (mod 2^AW).
  - A zero bound compares `0==0`, so `err` stays 0.
- Invariant during RUN: `x+y == (STEP_A+STEP_B)*i` for every selector sequence.
- Arithmetic: all sums wrap modulo 2^AW with no saturation. Defaults give a maximum of `3*(2^11-1)` < 2^13, so there is no wrap.

## Timing
- `start` is sampled at a rising edge; `busy`=1 from the next cycle.
- Loop with bound `n` and `k` stall cycles:
  - `done`=1 exactly `n+k` cycles after the start edge.
  - On the first `done` cycle, `i==n`.
- `done` and `err` are levels and hold until the next accepted `start` or reset.
- Restart from DONE: `start` clears `done` on the next cycle and begins counting from 0; no idle bubble.
- Reset mid-RUN: outputs take their reset values immediately (asynchronous), with no partial result retained. Leaving reset is synchronised to the first `clk` edge after `rst` returns high.
- Every output is registered; there are no combinational input-to-output paths.

## Test plan
- Reset with `AUTO_START=1`, `selector=00` held for 40 cycles -> `done`=1 in cycle 40, `x=40`, `y=80`, `i=n=40`, `err=0`.
- `start`, `n_in=5`, selector sequence 00,10,01,10,11,01,00 -> `done` after 7 cycles. Final values: `x=1+2+3+2+1=9`, `y=2+1+0+1+2=6`, `x+y=15`, `err=0`.
- `start` with `n_in=0` from IDLE -> DONE next cycle; `x=y=i=0`, `n=0`, `err=0`, `busy` never high.
- `start` pulsed mid-RUN (`n_in=3`, during the n=10 loop) -> ignored. Loop finishes with `n=10`, `x+y=30`.
- `rst`=0 asserted in the middle of the cycle-20 step of a 40-iteration loop -> outputs zero at once and `n=40`. Then `rst`=1 with `AUTO_START=0` -> IDLE, `busy`=0, `done`=0.
- Restart from DONE with `n_in=2047`, `selector=01` -> `done` after 2047 cycles, `x=4094`, `y=2047`, `x+y=6141`, `err=0`.
